// File: rtl/tty_uart_pkg.sv
// Shared types and constants for the teletype-to-serial bridge.
// Register indices and bit positions mirror the teletype interface register map.
package tty_uart_pkg;

   typedef enum logic [1:0] {
      POLL_KB = 2'd0,
      CHK_KB  = 2'd1,
      POLL_PR = 2'd2,
      CHK_PR  = 2'd3
   } poll_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [1:0] KBREG = 2'd1;
   localparam logic [1:0] PRREG = 2'd2;

   localparam int FLAGBIT = 31;
   localparam int ENBIT   = 30;
   localparam int FULLBIT = 30;

   // start + 8 data + stop
   localparam int FRAME_LEN = 10;

endpackage

// File: rtl/tty_uart_rx.sv
// 8N1 serial receiver: input synchronizer, mid-bit sampling FSM,
// sticky framing error and a one-cycle received-character pulse.
module tty_uart_rx
   import tty_uart_pkg::*;
#(
   parameter int BAUDDIV = 10417
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr
);

   localparam logic [15:0] BIT_LAST  = 16'(BAUDDIV - 1);
   localparam logic [15:0] HALF_LAST = 16'((BAUDDIV >> 1) - 1);

   rx_state_t   state_reg;
   logic        rxd_meta_reg;
   logic        rxd_sync_reg;
   logic        rxd_prev_reg;
   logic [15:0] cnt_reg;
   logic [2:0]  idx_reg;
   logic [7:0]  shift_reg;
   logic [7:0]  data_reg;
   logic        valid_reg;
   logic        ferr_reg;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg    <= RX_IDLE;
         rxd_meta_reg <= 1'b1;
         rxd_sync_reg <= 1'b1;
         rxd_prev_reg <= 1'b1;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         shift_reg    <= '0;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         ferr_reg     <= 1'b0;
      end else begin
         rxd_meta_reg <= rxd;
         rxd_sync_reg <= rxd_meta_reg;
         rxd_prev_reg <= rxd_sync_reg;
         valid_reg    <= 1'b0;
         case (state_reg)
            RX_IDLE: begin
               if (rxd_prev_reg && !rxd_sync_reg) begin
                  cnt_reg   <= '0;
                  state_reg <= RX_START;
               end
            end
            RX_START: begin
               // Line back high at mid start bit means a glitch, not a frame.
               if (cnt_reg == HALF_LAST) begin
                  cnt_reg <= '0;
                  if (rxd_sync_reg) begin
                     state_reg <= RX_IDLE;
                  end else begin
                     idx_reg   <= '0;
                     state_reg <= RX_DATA;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            RX_DATA: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg   <= '0;
                  shift_reg <= {rxd_sync_reg, shift_reg[7:1]};
                  idx_reg   <= idx_reg + 3'd1;
                  if (idx_reg == 3'd7) begin
                     state_reg <= RX_STOP;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            RX_STOP: begin
               if (cnt_reg == BIT_LAST) begin
                  cnt_reg   <= '0;
                  state_reg <= RX_IDLE;
                  if (rxd_sync_reg) begin
                     data_reg  <= shift_reg;
                     valid_reg <= 1'b1;
                  end else begin
                     ferr_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            default: state_reg <= RX_IDLE;
         endcase
      end
   end

   assign rx_data  = data_reg;
   assign rx_valid = valid_reg;
   assign rx_ferr  = ferr_reg;

endmodule

// File: rtl/tty_uart_bridge.sv
// Polls the teletype keyboard/printer registers in place of ARM software and
// bridges them to an 8N1 serial line (received chars -> kb, printer -> TXD).
module tty_uart_bridge
   import tty_uart_pkg::*;
#(
   parameter int BAUDDIV = 10417,
   parameter bit MARK7   = 1'b1
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        bridge_en,
   input  logic        rxd,
   output logic        txd,
   output logic [1:0]  tty_raddr,
   input  logic [31:0] tty_rdata,
   output logic        tty_write,
   output logic [1:0]  tty_waddr,
   output logic [31:0] tty_wdata,
   output logic        rx_ovr,
   output logic        rx_ferr
);

   localparam logic [15:0] BIT_LAST   = 16'(BAUDDIV - 1);
   localparam logic [3:0]  FRAME_LAST = 4'(FRAME_LEN - 1);
   localparam logic [31:0] PR_DONE    = 32'h1 << FLAGBIT;

   logic [7:0] rx_data;
   logic       rx_valid;

   tty_uart_rx #(
      .BAUDDIV (BAUDDIV)
   ) u_rx (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr)
   );

   poll_state_t state_reg;
   logic [11:0] hold_reg;
   logic        hold_v_reg;
   logic        rx_ovr_reg;
   logic        tx_busy_reg;
   logic        tx_done_reg;
   logic        tx_owned_reg;
   logic [9:0]  tx_shift_reg;
   logic [15:0] tx_cnt_reg;
   logic [3:0]  tx_bits_reg;
   logic        txd_reg;
   logic [1:0]  tty_raddr_reg;
   logic        tty_write_reg;
   logic [1:0]  tty_waddr_reg;
   logic [31:0] tty_wdata_reg;

   // Only flag, enable/full and the character byte matter to the bridge.
   logic unused_rdata;
   assign unused_rdata = ^tty_rdata[29:8];

   // Receive holding slot, transmitter and poller share one block because
   // the poller is the only thing that clears hold_v, tx_done and tx_owned.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg     <= POLL_KB;
         hold_reg      <= '0;
         hold_v_reg    <= 1'b0;
         rx_ovr_reg    <= 1'b0;
         tx_busy_reg   <= 1'b0;
         tx_done_reg   <= 1'b0;
         tx_owned_reg  <= 1'b0;
         tx_shift_reg  <= '1;
         tx_cnt_reg    <= '0;
         tx_bits_reg   <= '0;
         txd_reg       <= 1'b1;
         tty_raddr_reg <= '0;
         tty_write_reg <= 1'b0;
         tty_waddr_reg <= '0;
         tty_wdata_reg <= '0;
      end else begin
         tty_write_reg <= 1'b0;

         if (rx_valid) begin
            if (hold_v_reg) begin
               rx_ovr_reg <= 1'b1;
            end else begin
               hold_reg   <= {4'b0, (MARK7 ? 1'b1 : rx_data[7]), rx_data[6:0]};
               hold_v_reg <= 1'b1;
            end
         end

         if (tx_busy_reg) begin
            if (tx_cnt_reg == BIT_LAST) begin
               tx_cnt_reg <= '0;
               if (tx_bits_reg == FRAME_LAST) begin
                  tx_busy_reg <= 1'b0;
                  tx_done_reg <= 1'b1;
                  txd_reg     <= 1'b1;
               end else begin
                  tx_bits_reg  <= tx_bits_reg + 4'd1;
                  tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                  txd_reg      <= tx_shift_reg[1];
               end
            end else begin
               tx_cnt_reg <= tx_cnt_reg + 16'd1;
            end
         end

         if (!bridge_en) begin
            state_reg <= POLL_KB;
         end else begin
            case (state_reg)
               POLL_KB: begin
                  tty_raddr_reg <= KBREG;
                  state_reg     <= CHK_KB;
               end
               CHK_KB: begin
                  if (hold_v_reg && !tty_rdata[FLAGBIT]) begin
                     tty_write_reg <= 1'b1;
                     tty_waddr_reg <= KBREG;
                     tty_wdata_reg <= {1'b1, tty_rdata[ENBIT], 18'b0, hold_reg};
                     hold_v_reg    <= 1'b0;
                  end
                  state_reg <= POLL_PR;
               end
               POLL_PR: begin
                  tty_raddr_reg <= PRREG;
                  state_reg     <= CHK_PR;
               end
               CHK_PR: begin
                  // tx_owned blocks a reload until the done write reaches the interface.
                  if (tx_done_reg) begin
                     tty_write_reg <= 1'b1;
                     tty_waddr_reg <= PRREG;
                     tty_wdata_reg <= PR_DONE;
                     tx_done_reg   <= 1'b0;
                     tx_owned_reg  <= 1'b0;
                  end else if (tty_rdata[FULLBIT] && !tx_busy_reg && !tx_owned_reg) begin
                     tx_shift_reg <= {1'b1, tty_rdata[7:0], 1'b0};
                     tx_busy_reg  <= 1'b1;
                     tx_owned_reg <= 1'b1;
                     tx_cnt_reg   <= '0;
                     tx_bits_reg  <= '0;
                     txd_reg      <= 1'b0;
                  end
                  state_reg <= POLL_KB;
               end
               default: state_reg <= POLL_KB;
            endcase
         end
      end
   end

   assign txd       = txd_reg;
   assign tty_raddr = tty_raddr_reg;
   assign tty_write = tty_write_reg;
   assign tty_waddr = tty_waddr_reg;
   assign tty_wdata = tty_wdata_reg;
   assign rx_ovr    = rx_ovr_reg;

endmodule

// File: doc/tty_uart_bridge.md
# tty_uart_bridge

Hardware bridge between the teletype interface's ARM-side register port and a physical 8N1 serial line (RXD/TXD). It stands in for ARM software so the PDP-8/L console can run on a real terminal. It polls the keyboard register (1) and the printer register (2), shifts printer characters out on TXD, and deposits received characters as keyboard characters. It sits beside the teletype interface and owns its arm write port whenever `bridge_en` is high.

## Interface
- `BAUDDIV`, default 10417: CLOCK cycles per bit. The default gives 9600 baud at 100 MHz. Legal range is 16..65535.
- `MARK7`, default 1: when 1, received chars get bit 7 forced to 1 (ASR-33 mark parity). When 0, the 8 received bits pass unchanged.
- `CLOCK  in  1`: system clock.
- `RESET  in  1`: synchronous, active-high.
- `bridge_en  in  1`: when 0, the polling FSM stays in POLL_KB, `tty_write` is 0, and `txd` idles high. The receiver still runs.
- `rxd  in  1`: serial input, asynchronous, idle high.
- `txd  out  1`: serial output, idle high.
- `tty_raddr  out  2`: register index to read from the teletype interface.
- `tty_rdata  in  32`: combinational read data for `tty_raddr`.
- `tty_write  out  1`: one-cycle write strobe.
- `tty_waddr  out  2`: write register index.
- `tty_wdata  out  32`: write data.
- `rx_ovr  out  1`: sticky overrun; cleared only by RESET.
- `rx_ferr  out  1`: sticky framing error; cleared only by RESET.

## Operation
- **Receiver**
  - `rxd` passes through a 2-flop synchronizer.
  - In IDLE, a 1→0 edge starts a half-bit wait (`BAUDDIV/2`). If the line is high at that sample, it is a false start and the receiver returns to IDLE.
  - It then takes 8 data samples, LSB first, each `BAUDDIV` apart, then 1 stop sample.
  - Stop = 0: set `rx_ferr` and discard the char.
  - Stop = 1: if `hold_v` = 0, load `hold` = {4'b0, MARK7 ? 1 : b7, b6..b0} and set `hold_v`. If `hold_v` = 1, set `rx_ovr` and drop the new char; the old char is kept.
- **Transmitter**
  - Frame is start(0), 8 data bits LSB first (`prchar[7:0]`), stop(1), each bit `BAUDDIV` cycles.
  - `tx_busy` is high from load until the end of the stop bit. At the end of the stop bit, set `tx_done`.
- **Polling FSM** (round-robin, one register access per state)
  - POLL_KB: `tty_raddr`←1; go to CHK_KB.
  - CHK_KB: sample `tty_rdata`. If `hold_v` and bit31 (kbflag) = 0, then: `tty_write`=1, `tty_waddr`=1, `tty_wdata`={1, `tty_rdata`[30], 18'b0, `hold`}, and clear `hold_v`. Bit 30 (enable) is always preserved. Go to POLL_PR.
  - POLL_PR: `tty_raddr`←2; go to CHK_PR.
  - CHK_PR, first true condition wins:
    - If `tx_done`: write reg 2 = {1, 0, 30'b0} (prflag=1, prfull=0) and clear `tx_done`.
    - Else if bit30 (prfull) = 1, `tx_busy` = 0, and `tx_owned` = 0: load the shifter from `tty_rdata[7:0]` and set `tx_owned`. No write.
    - Go to POLL_KB.
  - `tx_owned` clears when the done write is issued. This prevents retransmitting while prfull is still 1.
- `bridge_en` falling mid-frame: the TX frame completes, but the done write is deferred until `bridge_en` returns.

## Timing
- **Reset values:** `txd`=1, `tty_write`=0, `tty_raddr`=0, `tty_waddr`=0, `tty_wdata`=0, `rx_ovr`=0, `rx_ferr`=0. Also `hold_v`=0, `tx_done`=0, `tx_owned`=0, FSM=POLL_KB, receiver IDLE.
- **Poll period:** 4 cycles. Register writes are single-cycle pulses, at most one per 2 cycles.
- **Read timing:** `tty_raddr` is registered. `tty_rdata` is sampled the following cycle.
- **RX latency:** from the stop-bit sample to the kbflag write is ≤ 5 cycles when kbflag = 0.
- **TX latency:** from prfull = 1 to the start bit on `txd` is ≤ 5 cycles. From the stop-bit end to the prflag write is ≤ 4 cycles.
- **Reset mid-frame:** `txd` goes high immediately; the partial char is lost; nothing is written.
- **Counters:** bit counters are 16-bit and wrap at `BAUDDIV`−1; the half-bit wait is `BAUDDIV>>1`.

## Structure
- Package `tty_uart_pkg` holds:
  - the FSM state enum (POLL_KB, CHK_KB, POLL_PR, CHK_PR);
  - register index constants `KBREG`=1 and `PRREG`=2;
  - bit positions `FLAGBIT`=31, `ENBIT`=30 and `FULLBIT`=30;
  - frame length 10.
- Sub-module `tty_uart_rx` contains the synchronizer, receive FSM, `rx_ferr`, and the data/valid pulse output.
- The transmitter and polling FSM live in the top module.

## Test plan
Benches run with `BAUDDIV`=16.
- **RX to keyboard:** with reg1 reading 0x40000000 (enable set, kbflag clear), receive 0x41 → `tty_write` to reg 1 with `tty_wdata`=0xC00000C1 (MARK7=1).
- **Printer:** reg2 reads prfull with prchar=0x0C5 → `txd` emits the bit sequence 0,1,0,1,0,0,0,1,1,1 at 16 cycles/bit. After the stop bit, reg 2 is written with 0x80000000; there is no second transmission while prfull is still 1.
- **Overrun:** kbflag held 1 while 0x31 then 0x32 are received → `rx_ovr`=1. When kbflag drops, a write with char 0x0B1 follows; 0x32 is never written.
- **Framing:** a frame with stop bit 0 → `rx_ferr`=1, `hold_v` stays 0, and there are no writes.
- **False start:** a 4-cycle low glitch on `rxd` → receiver returns to IDLE, with no error and no char.
- **Reset mid-TX:** assert RESET at bit 4 → `txd`=1 next cycle, all outputs at reset values, and no prflag write.
